// File: rtl/result_reader.sv
// Streams NUM_ROWS rows of packed signed partial sums from the result SRAM,
// one PARTIAL_SUM_BW element per valid/ready handshake, column 0 first.
module result_reader #(
  parameter int ADDRESSSIZE    = 10,
  parameter int PARTIAL_SUM_BW = 20,
  parameter int MATRIX_SIZE    = 8,
  parameter int NUM_ROWS       = 8
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  start,
  input  logic [ADDRESSSIZE-1:0]                base_address,
  output logic [ADDRESSSIZE-1:0]                sram_address,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_data_out,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [PARTIAL_SUM_BW-1:0]             out_data,
  output logic                                  out_last,
  output logic                                  busy,
  output logic                                  done,
  output logic [2:0]                            o_dbg_state
);

  localparam int CW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam int WW = PARTIAL_SUM_BW * MATRIX_SIZE;
  localparam logic [CW-1:0]          LAST_COL = CW'(MATRIX_SIZE - 1);
  localparam logic [ADDRESSSIZE-1:0] LAST_ROW = ADDRESSSIZE'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_LOAD = 3'd3,
    S_SEND = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [ADDRESSSIZE-1:0] r_base;
  logic [ADDRESSSIZE-1:0] r_row;
  logic [ADDRESSSIZE-1:0] r_addr;
  logic [CW-1:0]          r_col;
  logic [WW-1:0]          r_row_data;
  logic                   w_hs;
  logic                   w_last_col;
  logic                   w_last_row;

  // Handshake: a beat transfers only on a cycle where out_valid and
  // out_ready are both high; while out_valid is high and out_ready is low,
  // out_data/out_last/out_valid are held unchanged.
  assign w_hs       = (r_state == S_SEND) && out_ready;
  assign w_last_col = (r_col == LAST_COL);
  assign w_last_row = (r_row == LAST_ROW);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ADDR;
      S_ADDR:  w_next = S_WAIT;
      S_WAIT:  w_next = S_LOAD;
      S_LOAD:  w_next = S_SEND;
      S_SEND:  if (w_hs && w_last_col) w_next = w_last_row ? S_FIN : S_ADDR;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // The address register is loaded on entry to ADDR and otherwise holds,
  // so it stays stable through the one-cycle SRAM latency and after FIN.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_base     <= '0;
      r_row      <= '0;
      r_addr     <= '0;
      r_col      <= '0;
      r_row_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base <= base_address;
            r_row  <= '0;
            r_addr <= base_address;
          end
        end
        S_LOAD: begin
          r_row_data <= sram_data_out;
          r_col      <= '0;
        end
        S_SEND: begin
          if (w_hs) begin
            if (!w_last_col) begin
              r_col <= r_col + CW'(1);
            end else if (!w_last_row) begin
              r_row  <= r_row + ADDRESSSIZE'(1);
              r_addr <= r_base + r_row + ADDRESSSIZE'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sram_address = r_addr;
  assign out_valid    = (r_state == S_SEND);
  assign out_data     = out_valid ? r_row_data[r_col*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] : '0;
  assign out_last     = out_valid && w_last_col && w_last_row;
  assign busy         = (r_state != S_IDLE) && (r_state != S_FIN);
  assign done         = (r_state == S_FIN);
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_result_reader.sv
// Directed bench for result_reader: an 8-row instance checked against a
// scoreboard over a vector table, and a 1-row instance for the signed example.
module tb_result_reader;

  localparam int A   = 10;
  localparam int PSB = 20;
  localparam int MS  = 8;
  localparam int NR  = 8;
  localparam logic [2:0] ST_ADDR = 3'd1;

  typedef struct {
    logic [A-1:0] base;
    int           ready_pct;
    int           exp_cycles;
    bit           repulse;
  } xfer_t;

  typedef struct {
    logic [PSB-1:0] data;
    logic           last;
  } bvec_t;

  logic clk;
  logic rstn;

  logic              a_start, a_ready, a_valid, a_last, a_busy, a_done;
  logic [A-1:0]      a_base, a_addr;
  logic [PSB*MS-1:0] a_rdata;
  logic [PSB-1:0]    a_data;
  logic [2:0]        a_state;

  logic              b_start, b_ready, b_valid, b_last, b_busy, b_done;
  logic [A-1:0]      b_base, b_addr;
  logic [PSB*MS-1:0] b_rdata, b_row0;
  logic [PSB-1:0]    b_data;
  logic [2:0]        b_state;

  logic [PSB*MS-1:0] mem_a [1024];
  logic [PSB-1:0]    exp_q[$];
  logic [A-1:0]      exp_addr_q[$];

  int n_cmp, n_err, done_cnt;
  logic           mon_en, prev_stall, prev_last;
  logic [PSB-1:0] prev_data;

  xfer_t xv[5];
  bvec_t bv[8];

  result_reader #(.ADDRESSSIZE(A), .PARTIAL_SUM_BW(PSB), .MATRIX_SIZE(MS), .NUM_ROWS(NR)) u_dut (
    .clk(clk), .rstn(rstn), .start(a_start), .base_address(a_base),
    .sram_address(a_addr), .sram_data_out(a_rdata), .out_valid(a_valid),
    .out_ready(a_ready), .out_data(a_data), .out_last(a_last),
    .busy(a_busy), .done(a_done), .o_dbg_state(a_state)
  );

  result_reader #(.ADDRESSSIZE(A), .PARTIAL_SUM_BW(PSB), .MATRIX_SIZE(MS), .NUM_ROWS(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .start(b_start), .base_address(b_base),
    .sram_address(b_addr), .sram_data_out(b_rdata), .out_valid(b_valid),
    .out_ready(b_ready), .out_data(b_data), .out_last(b_last),
    .busy(b_busy), .done(b_done), .o_dbg_state(b_state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered-read SRAM models
  always @(posedge clk) a_rdata <= mem_a[a_addr];
  always @(posedge clk) b_rdata <= (b_addr == '0) ? b_row0 : '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the 8-row instance, sampled on the falling edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        check("stall_valid", 32'(a_valid), 32'd1);
        check("stall_data", 32'(a_data), 32'(prev_data));
        check("stall_last", 32'(a_last), 32'(prev_last));
      end
      if (!a_valid) check("idle_data_zero", 32'(a_data), 32'd0);
      if (a_valid && a_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_beat: got 0x%0h expected no beat", a_data);
        end else begin
          check("out_data", 32'(a_data), 32'(exp_q.pop_front()));
          check("out_last", 32'(a_last), 32'(exp_q.size() == 0));
        end
      end
      if (a_state == ST_ADDR) begin
        if (exp_addr_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_read: got addr 0x%0h expected no read", a_addr);
        end else begin
          check("sram_address", 32'(a_addr), 32'(exp_addr_q.pop_front()));
        end
      end
      if (a_done) done_cnt <= done_cnt + 1;
      prev_stall <= a_valid && !a_ready;
      prev_data  <= a_data;
      prev_last  <= a_last;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  // Driver: one full transfer on the 8-row instance
  task automatic run_xfer(input xfer_t v);
    int cyc;
    int d0;
    bit seen;
    logic [A-1:0] a;
    exp_q.delete();
    exp_addr_q.delete();
    for (int r = 0; r < NR; r++) begin
      a = v.base + A'(r);
      exp_addr_q.push_back(a);
      for (int c = 0; c < MS; c++) exp_q.push_back(PSB'(a * 8 + c));
    end
    @(posedge clk); #1;
    d0      = done_cnt;
    a_base  = v.base;
    a_start = 1'b1;
    a_ready = (v.ready_pct >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      a_start = v.repulse && (cyc == 5 || cyc == 30);
      a_ready = (v.ready_pct >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
      if (a_done) seen = 1;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL xfer_timeout: got no done after %0d cycles expected done", cyc);
    end
    if (v.exp_cycles > 0) check("start_to_done", 32'(cyc), 32'(v.exp_cycles));
    if (v.repulse) a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    a_ready = 1'b1;
    check("busy_after_fin", 32'(a_busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("beats_left", 32'(exp_q.size()), 32'd0);
    check("reads_left", 32'(exp_addr_q.size()), 32'd0);
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int cyc;
    int idx;
    bit seen;
    n_cmp = 0;
    n_err = 0;
    done_cnt = 0;
    mon_en = 1'b0;
    rstn = 1'b0;
    a_start = 1'b0; a_ready = 1'b1; a_base = '0;
    b_start = 1'b0; b_ready = 1'b1; b_base = '0;

    for (int r = 0; r < 1024; r++)
      for (int c = 0; c < MS; c++) mem_a[r][c*PSB +: PSB] = PSB'(r * 8 + c);
    b_row0 = '0;
    for (int c = 0; c < MS; c++) b_row0[c*PSB +: PSB] = (c % 2 == 0) ? PSB'(-(c + 1)) : PSB'(c + 1);

    xv[0] = '{base: 10'd0,    ready_pct: 100, exp_cycles: 89, repulse: 1'b0};
    xv[1] = '{base: 10'd0,    ready_pct: 50,  exp_cycles: -1, repulse: 1'b0};
    xv[2] = '{base: 10'd1022, ready_pct: 100, exp_cycles: 89, repulse: 1'b0};
    xv[3] = '{base: 10'd517,  ready_pct: 50,  exp_cycles: -1, repulse: 1'b0};
    xv[4] = '{base: 10'd3,    ready_pct: 100, exp_cycles: 89, repulse: 1'b1};

    bv[0] = '{data: 20'hFFFFF, last: 1'b0};
    bv[1] = '{data: 20'h00002, last: 1'b0};
    bv[2] = '{data: 20'hFFFFD, last: 1'b0};
    bv[3] = '{data: 20'h00004, last: 1'b0};
    bv[4] = '{data: 20'hFFFFB, last: 1'b0};
    bv[5] = '{data: 20'h00006, last: 1'b0};
    bv[6] = '{data: 20'hFFFF9, last: 1'b0};
    bv[7] = '{data: 20'h00008, last: 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_data", 32'(a_data), 32'd0);
    check("rst_last", 32'(a_last), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_addr", 32'(a_addr), 32'd0);
    check("rst_b_busy", 32'(b_busy), 32'd0);
    rstn = 1'b1;
    mon_en = 1'b1;

    // Table-driven transfers on the 8-row instance
    for (int i = 0; i < 5; i++) run_xfer(xv[i]);

    // Signed single-row example on the 1-row instance
    @(posedge clk); #1;
    b_start = 1'b1;
    b_base  = '0;
    idx = 0; cyc = 0; seen = 0;
    while (!seen && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      b_start = 1'b0;
      if (b_valid) begin
        if (idx < 8) begin
          check("b_out_data", 32'(b_data), 32'(bv[idx].data));
          check("b_out_last", 32'(b_last), 32'(bv[idx].last));
        end else begin
          n_cmp++;
          n_err++;
          $display("FAIL b_extra_beat: got 0x%0h expected no beat", b_data);
        end
        idx++;
      end
      if (b_done) seen = 1;
    end
    check("b_beats", 32'(idx), 32'd8);
    check("b_start_to_done", 32'(cyc), 32'd12);

    // Start during FIN is dropped; start in the following IDLE cycle is taken
    b_start = 1'b1;
    @(posedge clk); #1;
    check("b_fin_start_ignored", 32'(b_busy), 32'd0);
    @(posedge clk); #1;
    b_start = 1'b0;
    check("b_idle_start_taken", 32'(b_busy), 32'd1);
    cyc = 0; seen = 0;
    while (!seen && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (b_done) seen = 1;
    end
    check("b_second_done_seen", 32'(seen), 32'd1);

    // Asynchronous reset during SEND of row 3, then replay from row 0
    mon_en = 1'b0;
    @(posedge clk); #1;
    a_base = '0; a_ready = 1'b1; a_start = 1'b1;
    cyc = 0; seen = 0;
    while (!seen && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      a_start = 1'b0;
      if (a_valid && a_addr == 10'd3) seen = 1;
    end
    check("reach_row3_send", 32'(seen), 32'd1);
    #1 rstn = 1'b0;
    #1;
    check("async_rst_valid", 32'(a_valid), 32'd0);
    check("async_rst_busy", 32'(a_busy), 32'd0);
    check("async_rst_addr", 32'(a_addr), 32'd0);
    check("async_rst_data", 32'(a_data), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("post_rst_busy", 32'(a_busy), 32'd0);
      check("post_rst_valid", 32'(a_valid), 32'd0);
      check("post_rst_done", 32'(a_done), 32'd0);
    end
    mon_en = 1'b1;
    run_xfer(xv[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 SHALL have parameter ADDRESSSIZE, default 10, result SRAM address width.
REQ-002 SHALL have parameter PARTIAL_SUM_BW, default 20, width of one signed partial sum.
REQ-003 SHALL have parameter MATRIX_SIZE, default 8, partial sums per SRAM row.
REQ-004 SHALL have parameter NUM_ROWS, default 8, result rows read per transfer (1..2^ADDRESSSIZE).
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  transfer request pulse.
REQ-008 SHALL have port base_address  input  ADDRESSSIZE  first result row address, sampled on accepted start.
REQ-009 SHALL have port sram_address  output  ADDRESSSIZE  read address to result SRAM.
REQ-010 SHALL have port sram_data_out  input  PARTIAL_SUM_BW*MATRIX_SIZE  result SRAM read word.
REQ-011 SHALL have port out_valid  output  1  out_data holds a valid partial sum.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-013 SHALL have port out_data  output  PARTIAL_SUM_BW  signed partial sum.
REQ-014 SHALL have port out_last  output  1  marks final element of the transfer.
REQ-015 SHALL have port busy  output  1  high from accepted start until done.
REQ-016 SHALL have port done  output  1  one-cycle pulse after final handshake.

Function
REQ-017 SHALL implement FSM states IDLE, ADDR, WAIT, LOAD, SEND, FIN.
REQ-018 IDLE: start=1 SHALL capture base_address into row pointer, clear row counter, go to ADDR; start while not IDLE SHALL be ignored.
REQ-019 ADDR: sram_address SHALL equal base_address + row counter (wraps modulo 2^ADDRESSSIZE); next WAIT.
REQ-020 SRAM read latency SHALL be treated as one cycle: WAIT holds sram_address constant, next LOAD.
REQ-021 LOAD SHALL capture sram_data_out into a row register, clear column counter, go to SEND.
REQ-022 SEND SHALL drive out_valid=1, out_data = row register bits [(col+1)*PARTIAL_SUM_BW-1 : col*PARTIAL_SUM_BW], column 0 first.
REQ-023 A handshake SHALL occur only on a cycle with out_valid=1 and out_ready=1; column counter advances by one per handshake.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_last and out_valid SHALL hold stable.
REQ-025 Handshake on column MATRIX_SIZE-1: if row counter < NUM_ROWS-1, increment row counter, go to ADDR; else go to FIN.
REQ-026 out_valid SHALL be 0 in all states except SEND; out_data SHALL be 0 when out_valid=0.
REQ-027 out_last SHALL be 1 only in SEND with column MATRIX_SIZE-1 and row NUM_ROWS-1.
REQ-028 FIN SHALL assert done for exactly one cycle and return to IDLE; busy SHALL be 0 in IDLE and 1 in all other states except FIN.
REQ-029 With out_ready held 1, per-row cost SHALL be 3+MATRIX_SIZE cycles; start-to-done SHALL be NUM_ROWS*(3+MATRIX_SIZE)+1 cycles.
REQ-030 start asserted in the FIN cycle SHALL be ignored; start in the first IDLE cycle after FIN SHALL be accepted.
REQ-031 sram_address SHALL hold its last value in IDLE and FIN.

Reset
REQ-032 rstn=0 SHALL immediately force IDLE, out_valid=0, out_data=0, out_last=0, busy=0, done=0, sram_address=0, counters and row register cleared.
REQ-033 rstn deassertion mid-transfer SHALL not resume; a new start is required.

Verification
REQ-034 Row 0 word = sums 0..7 = {-1,2,-3,4,-5,6,-7,8}, base 0, NUM_ROWS=1, out_ready=1 -> out_data sequence 0xFFFFF,2,0xFFFFD,4,0xFFFFB,6,0xFFFF9,8, out_last on 8th, done 12 cycles after start.
REQ-035 NUM_ROWS=8, base 0, rows filled value=row*8+col, out_ready=1 -> 64 values 0..63 in order, sram_address steps 0..7, done at cycle 89.
REQ-036 out_ready toggled pseudo-randomly (50%) -> same 64-value order, no value dropped/duplicated, out_data stable during stall cycles.
REQ-037 base_address=1022, NUM_ROWS=4 -> sram_address sequence 1022,1023,0,1.
REQ-038 start re-pulsed while busy and during FIN -> ignored, single done pulse, no extra reads.
REQ-039 rstn pulsed low during SEND of row 3 -> out_valid, busy drop same cycle asynchronously; after release outputs idle until new start, which replays from row 0.
